mem_initiator: RTL and testbench

//  CPU-side initiator for the 512x32 memory subsystem. Accepts one read/write request

---
 rtl/mem_pkg.sv | 15 +
 rtl/mem_wait_counter.sv | 28 ++
 rtl/mem_initiator.sv | 110 +++++++++++
 tb/tb_mem_initiator.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared constants and FSM state encoding for the 512x32 memory subsystem
package mem_pkg;

   localparam int MEM_ADDR_W = 9;
   localparam int MEM_DATA_W = 32;
   localparam int MEM_DEPTH  = 512;
   localparam int CNT_W      = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

endpackage

// File: rtl/mem_wait_counter.sv
// rtl/mem_wait_counter.sv - loadable down-counter that times the memory access window
module mem_wait_counter
   import mem_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [CNT_W-1:0] count;

   // Saturates at zero so an idle decrement never wraps to 15.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/mem_initiator.sv
// rtl/mem_initiator.sv - single-outstanding CPU-side read/write initiator for the 512x32 memory
module mem_initiator
   import mem_pkg::*;
#(
   parameter int DATA_W      = MEM_DATA_W,
   parameter int ADDR_W      = MEM_ADDR_W,
   parameter int WAIT_CYCLES = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [31:0]       req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_dout
);

   localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES - 1);

   state_t state;
   state_t next_state;
   logic   fire;
   logic   addr_bad;
   logic   cnt_zero;
   logic   last_cycle;
   logic   wr_q;
   logic   err_q;

   assign fire       = req_valid && (state == ST_IDLE);
   assign addr_bad   = (req_addr[31:ADDR_W] != '0);
   assign last_cycle = (state == ST_ACCESS) && cnt_zero;

   mem_wait_counter u_wait (
      .clk      (clk),
      .reset    (reset),
      .load     (fire && !addr_bad),
      .load_val (WAIT_LOAD),
      .dec      (state == ST_ACCESS),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: begin
            if (fire) begin
               next_state = addr_bad ? ST_DONE : ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (cnt_zero) begin
               next_state = ST_DONE;
            end
         end
         ST_DONE: next_state = ST_IDLE;
         default: next_state = ST_IDLE;
      endcase
   end

   // Decoded straight from state so an async reset removes mem_write immediately.
   always_comb begin
      req_ready = (state == ST_IDLE);
      rsp_valid = (state == ST_DONE);
      rsp_err   = (state == ST_DONE) && err_q;
      mem_write = last_cycle && wr_q;
   end

   // An errored request leaves the memory lines at their previous values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_addr  <= '0;
         mem_din   <= '0;
         wr_q      <= 1'b0;
         err_q     <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         if (fire) begin
            wr_q <= req_write;
            if (addr_bad) begin
               err_q <= 1'b1;
            end else begin
               mem_addr <= req_addr[ADDR_W-1:0];
               mem_din  <= req_wdata;
            end
         end
         if (state == ST_DONE) begin
            err_q <= 1'b0;
         end
         if (last_cycle && !wr_q) begin
            rsp_rdata <= mem_dout;
         end
      end
   end

endmodule

// File: tb/tb_mem_initiator.sv
// tb/tb_mem_initiator.sv - self-checking bench: two initiators (1 and 3 wait cycles) on behavioural memories
module tb_mem_initiator;
   import mem_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [1:0]  req_valid, req_ready, req_write, rsp_valid, rsp_err, mem_write;
   logic [31:0] req_addr  [2];
   logic [31:0] req_wdata [2];
   logic [31:0] rsp_rdata [2];
   logic [31:0] mem_din   [2];
   logic [31:0] mem_dout  [2];
   logic [8:0]  mem_addr  [2];

   logic [31:0] mem     [2][MEM_DEPTH];
   logic [31:0] ref_mem [2][MEM_DEPTH];
   logic [31:0] exp_rdata [2];
   logic [8:0]  exp_maddr [2];
   logic [31:0] exp_mdin  [2];
   logic        init_mem;

   int checks = 0;
   int errors = 0;

   mem_initiator #(.DATA_W(32), .ADDR_W(9), .WAIT_CYCLES(1)) u_w1 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
      .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
      .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
      .mem_addr(mem_addr[0]), .mem_din(mem_din[0]), .mem_write(mem_write[0]),
      .mem_dout(mem_dout[0])
   );

   mem_initiator #(.DATA_W(32), .ADDR_W(9), .WAIT_CYCLES(3)) u_w3 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
      .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
      .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
      .mem_addr(mem_addr[1]), .mem_din(mem_din[1]), .mem_write(mem_write[1]),
      .mem_dout(mem_dout[1])
   );

   function automatic logic [31:0] seed_word(input int k, input int i);
      return (32'(k * 1024 + i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
   endfunction

   assign mem_dout[0] = mem[0][mem_addr[0]];
   assign mem_dout[1] = mem[1][mem_addr[1]];

   always @(posedge clk) begin
      if (init_mem) begin
         for (int i = 0; i < MEM_DEPTH; i++) begin
            mem[0][i] <= seed_word(0, i);
            mem[1][i] <= seed_word(1, i);
         end
      end else begin
         if (mem_write[0]) mem[0][mem_addr[0]] <= mem_din[0];
         if (mem_write[1]) mem[1][mem_addr[1]] <= mem_din[1];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Watches one request from the cycle after its accept edge up to the first idle cycle.
   task automatic observe(input int k, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input string tag);
      int   w = (k == 1) ? 3 : 1;
      bit   bad = (addr[31:9] != 23'd0);
      int   last = bad ? 2 : w + 2;
      int   rsp_n = 0, rsp_cyc = -1, wr_n = 0, wr_cyc = -1, ready_hi = 0, line_bad = 0;
      logic [31:0] rdata_at = 32'hx;
      logic        err_at = 1'bx;
      if (!bad) begin
         exp_maddr[k] = addr[8:0];
         exp_mdin[k]  = wdata;
      end
      for (int c = 1; c <= last; c++) begin
         @(negedge clk);
         if (c < last && req_ready[k]) ready_hi++;
         if (rsp_valid[k]) begin
            rsp_n++;
            rsp_cyc  = c;
            rdata_at = rsp_rdata[k];
            err_at   = rsp_err[k];
         end
         if (mem_write[k]) begin
            wr_n++;
            wr_cyc = c;
         end
         if (c < last && (mem_addr[k] !== exp_maddr[k] || mem_din[k] !== exp_mdin[k])) line_bad++;
      end
      if (!bad && wr) ref_mem[k][addr[8:0]] = wdata;
      if (!bad && !wr) exp_rdata[k] = ref_mem[k][addr[8:0]];
      chk({tag, "/rsp_count"}, 32'(rsp_n), 32'd1);
      chk({tag, "/rsp_cycle"}, 32'(rsp_cyc), bad ? 32'd1 : 32'(w + 1));
      chk({tag, "/rsp_err"}, 32'(err_at), 32'(bad));
      chk({tag, "/rsp_rdata"}, rdata_at, exp_rdata[k]);
      chk({tag, "/write_count"}, 32'(wr_n), (wr && !bad) ? 32'd1 : 32'd0);
      if (wr && !bad) chk({tag, "/write_cycle"}, 32'(wr_cyc), 32'(w));
      chk({tag, "/ready_busy"}, 32'(ready_hi), 32'd0);
      chk({tag, "/ready_after"}, 32'(req_ready[k]), 32'd1);
      chk({tag, "/mem_lines"}, 32'(line_bad), 32'd0);
      chk({tag, "/mem_word"}, mem[k][addr[8:0]], ref_mem[k][addr[8:0]]);
   endtask

   task automatic issue(input int k, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input string tag);
      int t = 0;
      @(negedge clk);
      while (!req_ready[k] && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk({tag, "/ready_pre"}, 32'(req_ready[k]), 32'd1);
      req_valid[k] = 1'b1;
      req_write[k] = wr;
      req_addr[k]  = addr;
      req_wdata[k] = wdata;
      @(posedge clk);
      #1;
      // Scramble the request bus: the in-flight access must not notice.
      req_valid[k] = 1'b0;
      req_write[k] = 1'($urandom);
      req_addr[k]  = $urandom;
      req_wdata[k] = $urandom;
      observe(k, wr, addr, wdata, tag);
   endtask

   task automatic back_to_back(input int k, input string tag);
      @(negedge clk);
      req_valid[k] = 1'b1;
      req_write[k] = 1'b0;
      req_addr[k]  = 32'h0000_0001;
      req_wdata[k] = 32'h0000_1111;
      @(posedge clk);
      #1;
      req_addr[k] = 32'h0000_01FF;
      observe(k, 1'b0, 32'h0000_0001, 32'h0000_1111, {tag, "/first"});
      @(posedge clk);
      #1;
      req_valid[k] = 1'b0;
      observe(k, 1'b0, 32'h0000_01FF, 32'h0000_1111, {tag, "/second"});
   endtask

   initial begin
      logic [31:0] a;
      int rv;
      reset     = 1'b1;
      init_mem  = 1'b1;
      req_valid = '0;
      req_write = '0;
      for (int k = 0; k < 2; k++) begin
         req_addr[k]  = '0;
         req_wdata[k] = '0;
         exp_rdata[k] = '0;
         exp_maddr[k] = '0;
         exp_mdin[k]  = '0;
         for (int i = 0; i < MEM_DEPTH; i++) ref_mem[k][i] = seed_word(k, i);
      end
      @(posedge clk);
      @(posedge clk);
      init_mem = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      for (int k = 0; k < 2; k++) begin
         chk($sformatf("reset%0d/req_ready", k), 32'(req_ready[k]), 32'd1);
         chk($sformatf("reset%0d/mem_write", k), 32'(mem_write[k]), 32'd0);
         chk($sformatf("reset%0d/rsp_valid", k), 32'(rsp_valid[k]), 32'd0);
         chk($sformatf("reset%0d/rsp_err", k), 32'(rsp_err[k]), 32'd0);
         chk($sformatf("reset%0d/rsp_rdata", k), rsp_rdata[k], 32'd0);
         chk($sformatf("reset%0d/mem_addr", k), 32'(mem_addr[k]), 32'd0);
      end

      issue(0, 1'b1, 32'h0000_0005, 32'hDEAD_BEEF, "w1_wr5");
      chk("w1_wr5/mem5", mem[0][5], 32'hDEAD_BEEF);
      issue(0, 1'b0, 32'h0000_0005, 32'h0, "w1_rd5");
      issue(1, 1'b1, 32'h0000_0005, 32'hDEAD_BEEF, "w3_wr5");
      issue(1, 1'b0, 32'h0000_0005, 32'h0, "w3_rd5");
      issue(0, 1'b1, 32'h0000_0200, 32'h1234_5678, "w1_oor_wr");
      chk("w1_oor_wr/mem0", mem[0][0], seed_word(0, 0));
      issue(1, 1'b0, 32'h8000_0000, 32'h0, "w3_oor_rd");
      issue(0, 1'b1, 32'h0000_01FF, 32'hA5A5_0F0F, "w1_wr_top");
      issue(0, 1'b0, 32'h0000_01FF, 32'h0, "w1_rd_top");

      back_to_back(0, "w1_b2b");
      back_to_back(1, "w3_b2b");

      for (int n = 0; n < 40; n++) begin
         for (int k = 0; k < 2; k++) begin
            if ($urandom_range(0, 7) == 0) begin
               a = $urandom;
               if (a[31:9] == 23'd0) a[9] = 1'b1;
            end else begin
               a = 32'($urandom_range(0, 511));
            end
            issue(k, 1'($urandom), a, $urandom, $sformatf("rnd%0d_%0d", k, n));
         end
      end

      // Reset during the committing cycle of a 3-cycle write: the write must be lost.
      @(negedge clk);
      req_valid[1] = 1'b1;
      req_write[1] = 1'b1;
      req_addr[1]  = 32'h0000_000A;
      req_wdata[1] = 32'hCAFE_F00D;
      @(posedge clk);
      #1;
      req_valid[1] = 1'b0;
      @(negedge clk);
      chk("rst/c1_mem_write", 32'(mem_write[1]), 32'd0);
      @(negedge clk);
      @(negedge clk);
      chk("rst/c3_mem_write", 32'(mem_write[1]), 32'd1);
      reset = 1'b1;
      #1;
      chk("rst/mem_write_drop", 32'(mem_write[1]), 32'd0);
      chk("rst/ready_async", 32'(req_ready[1]), 32'd1);
      chk("rst/rsp_valid_async", 32'(rsp_valid[1]), 32'd0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 2; k++) begin
         exp_rdata[k] = '0;
         exp_maddr[k] = '0;
         exp_mdin[k]  = '0;
      end
      rv = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (rsp_valid[1]) rv++;
      end
      chk("rst/no_rsp", 32'(rv), 32'd0);
      chk("rst/word_kept", mem[1][10], ref_mem[1][10]);
      chk("rst/ready_after", 32'(req_ready[1]), 32'd1);
      chk("rst/rdata_cleared", rsp_rdata[1], 32'd0);
      issue(1, 1'b0, 32'h0000_000A, 32'h0, "rst/read_back");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
